// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment patterns for every code,
// the blank pattern and the code-to-pattern lookup used by the encoder.
// Bit order of every pattern is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b0000000;

    // Decimal digits
    localparam seg_t SEG_0 = 7'b0111111;
    localparam seg_t SEG_1 = 7'b0000110;
    localparam seg_t SEG_2 = 7'b1011011;
    localparam seg_t SEG_3 = 7'b1001111;
    localparam seg_t SEG_4 = 7'b1100110;
    localparam seg_t SEG_5 = 7'b1101101;
    localparam seg_t SEG_6 = 7'b1111100;
    localparam seg_t SEG_7 = 7'b0100111;
    localparam seg_t SEG_8 = 7'b1111111;
    localparam seg_t SEG_9 = 7'b1100111;

    // Hex letters A, b, C, d, E, F
    localparam seg_t SEG_A = 7'b1110111;
    localparam seg_t SEG_B = 7'b1111100;
    localparam seg_t SEG_C = 7'b0111001;
    localparam seg_t SEG_D = 7'b1011110;
    localparam seg_t SEG_E = 7'b1111001;
    localparam seg_t SEG_F = 7'b1110001;

    // Codes 10..15 render as letters only when hex_en is set, otherwise dark.
    function automatic seg_t seg_lookup(input logic [3:0] code, input logic hex_en);
        seg_t s;
        case (code)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            4'd10:   s = hex_en ? SEG_A : SEG_BLANK;
            4'd11:   s = hex_en ? SEG_B : SEG_BLANK;
            4'd12:   s = hex_en ? SEG_C : SEG_BLANK;
            4'd13:   s = hex_en ? SEG_D : SEG_BLANK;
            4'd14:   s = hex_en ? SEG_E : SEG_BLANK;
            default: s = hex_en ? SEG_F : SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_7seg_scan_if.sv
// Update handshake bundle of the scanned display: a producer offers a new
// value/decimal-point/blanking set with load, the display answers with ready.
interface bcd_7seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic                    ready;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz;

    modport master (output load, value, dp_in, blank_lz, input ready);
    modport slave  (input load, value, dp_in, blank_lz, output ready);
endinterface

// File: rtl/bcd7_encode.sv
// Combinational code-to-segment decoder for a single digit.
module bcd7_encode
    import seg7_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       hex_en_i,
    output seg_t       seg_o
);

    // Pure table lookup; blanking and polarity are handled by the caller.
    always_comb begin
        seg_o = seg_lookup(code_i, hex_en_i);
    end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Multiplexed seven-segment scanner. A prescaler paces a digit index that
// walks across the display; updates are double-buffered so a new value only
// becomes visible at a frame boundary and never tears mid-scan.
module bcd_7seg_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int HEX_MODE    = 0,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    output logic                    ready,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int PRESC_W = $clog2(REFRESH_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic               POL        = (ACTIVE_LOW != 0);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               tick, frame;

    logic                    pending_q;
    logic [4*NUM_DIGITS-1:0] pend_value_q, disp_value_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q, disp_dp_q;
    logic                    pend_blz_q, disp_blz_q;

    logic [NUM_DIGITS-1:0] lz_blank;
    logic [3:0]            cur_nibble;
    logic                  cur_dp, cur_blank;
    seg_t                  enc_seg;
    seg_t                  seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    // Leading-zero mask: digit gi is dark when it and every more significant
    // nibble are zero. Digit 0 always shows, so a zero value reads "0".
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
            if (gi == 0) begin : g_first
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = disp_blz_q &&
                                      (disp_value_q[4*NUM_DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    // Scan timing: tick at the prescaler terminal count, frame when the tick
    // wraps the index back to digit 0.
    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        frame   = tick && (idx_q == IDX_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Select the currently scanned digit's nibble, decimal point and blanking.
    always_comb begin
        cur_nibble = 4'd0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        an_d       = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nibble = disp_value_q[4*i +: 4];
                cur_dp     = disp_dp_q[i];
                cur_blank  = lz_blank[i];
                an_d[i]    = 1'b1;
            end
        end
        seg_d = cur_blank ? SEG_BLANK : enc_seg;
        dp_d  = cur_dp;
    end

    bcd7_encode u_encode (
        .code_i   (cur_nibble),
        .hex_en_i (HEX_MODE != 0),
        .seg_o    (enc_seg)
    );

    // Prescaler and digit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    // Update handshake: accept into pending only while idle, then promote
    // pending to the display at the next frame boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q    <= 1'b0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_blz_q   <= 1'b0;
            disp_value_q <= '0;
            disp_dp_q    <= '0;
            disp_blz_q   <= 1'b0;
        end else if (load && !pending_q) begin
            pending_q    <= 1'b1;
            pend_value_q <= value;
            pend_dp_q    <= dp_in;
            pend_blz_q   <= blank_lz;
        end else if (frame && pending_q) begin
            pending_q    <= 1'b0;
            disp_value_q <= pend_value_q;
            disp_dp_q    <= pend_dp_q;
            disp_blz_q   <= pend_blz_q;
        end
    end

    // Registered pin drivers so the display sees glitch-free levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b0;
            an_q  <= '0;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign ready = ~pending_q;
    assign seg   = seg_q ^ {7{POL}};
    assign dp    = dp_q ^ POL;
    assign an    = an_q ^ {NUM_DIGITS{POL}};

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Bench for bcd_7seg_scan: three instances (decimal, hex, hex active-low)
// share one stimulus; an arithmetic model predicts every output each cycle
// and directed checks pin the model with hand-derived literals.
module tb_bcd_7seg_scan;

    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int FRAME = N * RD;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bcd_7seg_scan_if #(.NUM_DIGITS(N)) bus ();

    logic         ready_dec, ready_hex, ready_al;
    logic [6:0]   seg_dec, seg_hex, seg_al;
    logic         dp_dec, dp_hex, dp_al;
    logic [N-1:0] an_dec, an_hex, an_al;

    assign bus.ready = ready_dec;

    bcd_7seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .HEX_MODE(0), .ACTIVE_LOW(0)) u_dec (
        .clk(clk), .reset(reset), .load(bus.load), .ready(ready_dec), .value(bus.value),
        .dp_in(bus.dp_in), .blank_lz(bus.blank_lz), .seg(seg_dec), .dp(dp_dec), .an(an_dec));

    bcd_7seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .HEX_MODE(1), .ACTIVE_LOW(0)) u_hex (
        .clk(clk), .reset(reset), .load(bus.load), .ready(ready_hex), .value(bus.value),
        .dp_in(bus.dp_in), .blank_lz(bus.blank_lz), .seg(seg_hex), .dp(dp_hex), .an(an_hex));

    bcd_7seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .HEX_MODE(1), .ACTIVE_LOW(1)) u_al (
        .clk(clk), .reset(reset), .load(bus.load), .ready(ready_al), .value(bus.value),
        .dp_in(bus.dp_in), .blank_lz(bus.blank_lz), .seg(seg_al), .dp(dp_al), .an(an_al));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] dec_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                 7'b1101101, 7'b1111100, 7'b0100111, 7'b1111111, 7'b1100111};
    logic [6:0] hex_tab [6]  = '{7'b1110111, 7'b1111100, 7'b0111001, 7'b1011110, 7'b1111001,
                                 7'b1110001};

    function automatic logic [6:0] model_seg(input logic [15:0] v, input logic blz,
                                             input int d, input bit hex_on);
        logic [15:0] upper;
        int code;
        upper = v >> (4 * d);
        code  = int'(upper & 16'h000F);
        if (blz && d > 0 && upper == 16'h0000) return 7'b0000000;
        if (code < 10) return dec_tab[code];
        if (hex_on) return hex_tab[code - 10];
        return 7'b0000000;
    endfunction

    // m_k = rising edges since reset; the digit scanned before edge k+1 is (k/RD)%N.
    int          m_k = 0;
    logic        m_pending;
    logic [15:0] m_pval, m_dval;
    logic [3:0]  m_pdp, m_ddp;
    logic        m_pblz, m_dblz;
    logic [6:0]  exp_dec, exp_hex;
    logic        exp_dp;
    logic [3:0]  exp_an;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_k <= 0; m_pending <= 1'b0;
            m_pval <= '0; m_pdp <= '0; m_pblz <= 1'b0;
            m_dval <= '0; m_ddp <= '0; m_dblz <= 1'b0;
            exp_dec <= '0; exp_hex <= '0; exp_dp <= 1'b0; exp_an <= '0;
        end else begin
            m_k     <= m_k + 1;
            exp_an  <= 4'(1 << ((m_k / RD) % N));
            exp_dp  <= m_ddp[(m_k / RD) % N];
            exp_dec <= model_seg(m_dval, m_dblz, (m_k / RD) % N, 1'b0);
            exp_hex <= model_seg(m_dval, m_dblz, (m_k / RD) % N, 1'b1);
            if (bus.load && !m_pending) begin
                m_pending <= 1'b1;
                m_pval <= bus.value; m_pdp <= bus.dp_in; m_pblz <= bus.blank_lz;
            end else if (((m_k + 1) % FRAME == 0) && m_pending) begin
                m_pending <= 1'b0;
                m_dval <= m_pval; m_ddp <= m_pdp; m_dblz <= m_pblz;
            end
        end
    end

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        check("ready_dec", {31'b0, ready_dec}, {31'b0, !m_pending});
        check("ready_hex", {31'b0, ready_hex}, {31'b0, !m_pending});
        check("ready_al",  {31'b0, ready_al},  {31'b0, !m_pending});
        check("seg_dec",   {25'b0, seg_dec},   {25'b0, exp_dec});
        check("seg_hex",   {25'b0, seg_hex},   {25'b0, exp_hex});
        check("seg_al",    {25'b0, seg_al},    {25'b0, ~exp_hex});
        check("an_dec",    {28'b0, an_dec},    {28'b0, exp_an});
        check("an_al",     {28'b0, an_al},     {28'b0, ~exp_an});
        check("dp_dec",    {31'b0, dp_dec},    {31'b0, exp_dp});
        check("dp_al",     {31'b0, dp_al},     {31'b0, ~exp_dp});
    end

    // ---------------- directed stimulus ----------------
    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic blz);
        $display("load value=%h dp_in=%b blank_lz=%b ready=%b t=%0t", v, d, blz, bus.ready, $time);
        bus.load = 1'b1; bus.value = v; bus.dp_in = d; bus.blank_lz = blz;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_digit(input int d);
        bit seen = 1'b0;
        for (int c = 0; c < 4 * FRAME && !seen; c++) begin
            if (an_dec == 4'(1 << d)) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL wait_digit%0d: timeout, an=%b", d, an_dec);
        end
    endtask

    // Wait for a committed update, then one more cycle so outputs use it.
    task automatic wait_update();
        bit seen = 1'b0;
        for (int c = 0; c < 4 * FRAME && !seen; c++) begin
            @(negedge clk);
            if (ready_dec === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL wait_update: timeout, ready=%b", ready_dec);
        end
        @(negedge clk);
    endtask

    task automatic show_check(input int d, input logic [6:0] e_dec, input logic [6:0] e_hex);
        wait_digit(d);
        check($sformatf("lit_dec_d%0d", d), {25'b0, seg_dec}, {25'b0, e_dec});
        check($sformatf("lit_hex_d%0d", d), {25'b0, seg_hex}, {25'b0, e_hex});
        check($sformatf("lit_al_d%0d", d),  {25'b0, seg_al},  {25'b0, ~e_hex});
        $display("digit %0d: seg_dec=%b seg_hex=%b seg_al=%b dp=%b", d, seg_dec, seg_hex, seg_al, dp_dec);
    endtask

    initial begin
        bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.blank_lz = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_seg", {25'b0, seg_dec}, 32'h0);
        check("rst_an", {28'b0, an_dec}, 32'h0);
        check("rst_ready", {31'b0, ready_dec}, 32'h1);
        check("rst_seg_al", {25'b0, seg_al}, 32'h7F);
        check("rst_an_al", {28'b0, an_al}, 32'hF);
        check("rst_dp_al", {31'b0, dp_al}, 32'h1);
        reset = 1'b0;

        // Scan after reset: each digit for RD cycles, digit 0 shows "0".
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clk);
            check("scan_an", {28'b0, an_dec}, 32'(1 << (j / RD)));
            if (j == 0) check("scan_seg0", {25'b0, seg_dec}, 32'h3F);
        end
        $display("scan frame complete");

        // Mid-frame load of 1234.
        repeat (5) @(negedge clk);
        do_load(16'h1234, 4'b0001, 1'b0);
        check("ready_low", {31'b0, ready_dec}, 32'h0);
        wait_update();
        show_check(0, 7'b1100110, 7'b1100110);
        check("dp_d0", {31'b0, dp_dec}, 32'h1);
        show_check(3, 7'b0000110, 7'b0000110);
        check("ready_back", {31'b0, ready_dec}, 32'h1);

        // Leading-zero blanking of 0070.
        do_load(16'h0070, 4'b0000, 1'b1);
        wait_update();
        show_check(0, 7'b0111111, 7'b0111111);
        show_check(1, 7'b0100111, 7'b0100111);
        show_check(2, 7'b0000000, 7'b0000000);
        show_check(3, 7'b0000000, 7'b0000000);

        // Second load while busy is ignored.
        do_load(16'h5678, 4'b0000, 1'b0);
        do_load(16'h9999, 4'b1111, 1'b0);
        wait_update();
        show_check(0, 7'b1111111, 7'b1111111);
        check("ignored_dp", {31'b0, dp_dec}, 32'h0);
        show_check(3, 7'b1101101, 7'b1101101);

        // Hex codes: dark in decimal mode, letters in hex mode.
        do_load(16'hABCD, 4'b1010, 1'b0);
        wait_update();
        show_check(0, 7'b0000000, 7'b1011110);
        show_check(1, 7'b0000000, 7'b0111001);
        check("hex_dp_d1", {31'b0, dp_dec}, 32'h1);
        show_check(2, 7'b0000000, 7'b1111100);
        show_check(3, 7'b0000000, 7'b1110111);

        // Load on the exact frame-boundary cycle waits a whole extra frame.
        begin
            bit hit = 1'b0;
            for (int c = 0; c < 4 * FRAME && !hit; c++) begin
                if (ready_dec === 1'b1 && ((m_k + 1) % FRAME == 0)) hit = 1'b1;
                else @(negedge clk);
            end
            if (!hit) begin
                n_cmp++; n_err++;
                $display("FAIL boundary_align: timeout");
            end
        end
        do_load(16'h0909, 4'b0000, 1'b0);
        repeat (FRAME - 1) @(negedge clk);
        check("boundary_still_pending", {31'b0, ready_dec}, 32'h0);
        @(negedge clk);
        check("boundary_commit", {31'b0, ready_dec}, 32'h1);
        @(negedge clk);
        show_check(0, 7'b1100111, 7'b1100111);
        show_check(1, 7'b0111111, 7'b0111111);

        // Asynchronous reset while an update is pending.
        do_load(16'h4321, 4'b1111, 1'b0);
        check("pend_before_rst", {31'b0, ready_dec}, 32'h0);
        #2 reset = 1'b1;
        #1;
        check("async_ready", {31'b0, ready_dec}, 32'h1);
        check("async_seg", {25'b0, seg_dec}, 32'h0);
        check("async_an", {28'b0, an_dec}, 32'h0);
        check("async_seg_al", {25'b0, seg_al}, 32'h7F);
        check("async_an_al", {28'b0, an_al}, 32'hF);
        $display("async reset asserted t=%0t", $time);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2 * FRAME) @(negedge clk);
        show_check(0, 7'b0111111, 7'b0111111);
        show_check(3, 7'b0111111, 7'b0111111);
        check("post_rst_ready", {31'b0, ready_dec}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_7seg_scan.md
BCD_7SEG_SCAN -- requirements
Module: bcd_7seg_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 1000: clock cycles each digit is driven, minimum 2.
REQ-003 SHALL have parameter HEX_MODE, default 0: 1 decodes codes 10..15 as A..F, 0 blanks them.
REQ-004 SHALL have parameter ACTIVE_LOW, default 0: 1 inverts seg, dp and an at the output pins.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-007 SHALL have port load, input, 1 bit: request to capture value, dp_in and blank_lz.
REQ-008 SHALL have port ready, output, 1 bit: 1 when no update is pending.
REQ-009 SHALL have port value, input, 4*NUM_DIGITS bits: nibble i is the code for digit i, digit 0 least significant.
REQ-010 SHALL have port dp_in, input, NUM_DIGITS bits: decimal point per digit.
REQ-011 SHALL have port blank_lz, input, 1 bit: enables leading-zero blanking.
REQ-012 SHALL have port seg, output, 7 bits: {g,f,e,d,c,b,a}, active-high before polarity.
REQ-013 SHALL have port dp, output, 1 bit: decimal point of the digit currently driven.
REQ-014 SHALL have port an, output, NUM_DIGITS bits: one-hot enable of the digit currently driven.

Function
REQ-015 Decimal codes SHALL be 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111100, 7=0100111, 8=1111111, 9=1100111.
REQ-016 With HEX_MODE=1, codes SHALL be A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001; with HEX_MODE=0, codes 10..15 SHALL give seg=0000000.
REQ-017 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap; its terminal count is a tick.
REQ-018 On each tick the digit index SHALL advance by 1, wrapping from NUM_DIGITS-1 to 0; the tick that wraps to 0 is the frame boundary.
REQ-019 seg, dp and an SHALL be registered, reflecting the display register at the current index one cycle after the index changes.
REQ-020 load while ready=1 SHALL capture value, dp_in and blank_lz into a pending register and drive ready=0 on the next cycle.
REQ-021 load while ready=0 SHALL be ignored, with no change to the pending or display registers.
REQ-022 At a frame boundary with an update pending, the pending register SHALL copy into the display register, and ready SHALL return to 1 on the next cycle.
REQ-023 load accepted on the same cycle as a frame boundary SHALL go only to pending and take effect at the following frame boundary.
REQ-024 With blank_lz=1, digit i>0 SHALL show seg=0000000 when nibbles i..NUM_DIGITS-1 are all 0; digit 0 SHALL never be blanked.
REQ-025 dp SHALL follow the displayed dp_in bit regardless of blanking.
REQ-026 ACTIVE_LOW inversion SHALL be applied after all other logic.

Reset
REQ-027 reset SHALL asynchronously clear the prescaler, index, pending flag, pending register and display register.
REQ-028 During reset, ready SHALL be 1 and seg, dp and an SHALL be at their inactive level (all 0, or all 1 when ACTIVE_LOW=1).
REQ-029 After reset deasserts, the first clock SHALL drive digit 0 of the cleared display, showing "0".
REQ-030 reset mid-operation SHALL discard any pending update.

Structure
REQ-031 Segment code constants, the hex-code table and the blank pattern SHALL live in shared package seg7_pkg.
REQ-032 Digit-to-segment decoding SHALL be one combinational sub-module, bcd7_encode (4-bit code and hex enable in, 7-bit seg out), instantiated once on the muxed nibble.
REQ-033 The prescaler, index, handshake and output registers SHALL be in the top module; no other sub-modules.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-034 Scenario: release reset -> an cycles 0001, 0010, 0100, 1000 every 4 clocks; seg=0111111 on digit 0; seg=0000000 with blank_lz=0 not yet loaded is not required, since the display is all zeros.
REQ-035 Scenario: load value=16'h1234 mid-frame -> ready=0 next cycle; seg unchanged until the frame boundary; then digit 0 shows 1100110 and digit 3 shows 0000110; ready=1.
REQ-036 Scenario: load 16'h0070 with blank_lz=1 -> digits 3 and 2 show 0000000, digit 1 shows 0100111, digit 0 shows 0111111.
REQ-037 Scenario: second load while ready=0 -> ignored; the first value is displayed.
REQ-038 Scenario: HEX_MODE=0 vs 1 with 16'hABCD -> all digits blank vs 1110111, 1111100, 0111001, 1011110; ACTIVE_LOW=1 gives bitwise inverses.
REQ-039 Scenario: assert reset while pending -> ready=1 and outputs inactive immediately (asynchronous); the old pending value never appears.
